// File: rtl/qsched_pkg.sv
// qsched_pkg: reason codes, state encodings and default OS/user pc boundary for quantum_scheduler.
package qsched_pkg;
    typedef enum logic [1:0] {REASON_QUANTUM = 2'd0, REASON_IO = 2'd1, REASON_DONE = 2'd2} reason_t;
    typedef enum logic {ST_RUN = 1'b0, ST_REQ = 1'b1} state_t;
    localparam int OS_PC_LIMIT_DEFAULT = 300;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority search for the first active slot after cur_pid, cur_pid itself last.
module rr_pick #(
    parameter int NPROC = 8,
    parameter int PID_W = 3
) (
    input  logic [NPROC-1:0] active_mask,
    input  logic [PID_W-1:0] cur_pid,
    output logic [PID_W-1:0] next_pid,
    output logic             next_valid
);
    logic [PID_W-1:0] idx;
    always_comb begin
        next_pid = '0;
        next_valid = 1'b0;
        idx = '0;
        // Farthest candidate first so the nearest one overwrites; i == NPROC wraps back to cur_pid.
        for (int i = NPROC; i >= 1; i--) begin
            idx = cur_pid + PID_W'(i);
            if (active_mask[idx]) begin
                next_pid = idx;
                next_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: preemptive round-robin quantum scheduler with saved-pc table.
// Define QSCHED_STATS_EN to add preempt_count/io_count statistics outputs.
module quantum_scheduler import qsched_pkg::*; #(
    parameter int NPROC       = 8,
    parameter int PID_W       = 3,
    parameter int PC_W        = 32,
    parameter int QUANTUM     = 5,
    parameter int OS_PC_LIMIT = OS_PC_LIMIT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [PC_W-1:0]  pc,
    input  logic             io_instr,
    input  logic             proc_done,
    input  logic [PID_W-1:0] cur_pid,
    input  logic             create_valid,
    input  logic [PID_W-1:0] create_pid,
    input  logic [PC_W-1:0]  create_pc,
    input  logic             switch_ack,
    output logic             switch_req,
    output logic [1:0]       switch_reason,
    output logic [PID_W-1:0] saved_pid,
    output logic [PC_W-1:0]  saved_pc,
    output logic             next_valid,
    output logic [PID_W-1:0] next_pid,
    output logic [PC_W-1:0]  next_pc,
    output logic [NPROC-1:0] active_mask
`ifdef QSCHED_STATS_EN
    ,
    output logic [31:0]      preempt_count,
    output logic [31:0]      io_count
`endif
);
    state_t state, state_d;
    logic [15:0] cnt;
    logic [PC_W-1:0] pc_tab [NPROC];
    logic [PC_W-1:0] pc_tab_d [NPROC];
    logic [NPROC-1:0] mask_d;
    logic user, fire_done, fire_io, fire_q, fire, create_ok, pick_valid;
    logic [PID_W-1:0] pick_pid;

    assign user      = state == ST_RUN && instr_valid && pc > PC_W'(OS_PC_LIMIT);
    assign fire_done = user && proc_done;
    assign fire_io   = user && !proc_done && io_instr;
    assign fire_q    = user && !proc_done && !io_instr && cnt + 16'd1 == 16'(QUANTUM);
    assign fire      = fire_done || fire_io || fire_q;
    // A slot freed by proc_done this cycle may be re-created in the same cycle.
    assign create_ok = create_valid && (!active_mask[create_pid] || (fire_done && create_pid == cur_pid));

    always_comb begin
        state_d = state == ST_REQ ? (switch_ack ? ST_RUN : ST_REQ) : (fire ? ST_REQ : ST_RUN);
        mask_d = active_mask;
        pc_tab_d = pc_tab;
        if (fire_done) mask_d[cur_pid] = 1'b0;
        if (fire_io || fire_q) pc_tab_d[cur_pid] = pc + PC_W'(1);
        if (create_ok) begin
            mask_d[create_pid] = 1'b1;
            pc_tab_d[create_pid] = create_pc;
        end
    end

    rr_pick #(.NPROC(NPROC), .PID_W(PID_W)) u_pick (
        .active_mask(mask_d),
        .cur_pid(cur_pid),
        .next_pid(pick_pid),
        .next_valid(pick_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            cnt <= '0;
            active_mask <= '0;
            for (int i = 0; i < NPROC; i++) pc_tab[i] <= '0;
            switch_req <= 1'b0;
            switch_reason <= '0;
            saved_pid <= '0;
            saved_pc <= '0;
            next_valid <= 1'b0;
            next_pid <= '0;
            next_pc <= '0;
        end else begin
            state <= state_d;
            active_mask <= mask_d;
            pc_tab <= pc_tab_d;
            cnt <= (fire || state == ST_REQ) ? '0 : user ? cnt + 16'd1 : cnt;
            switch_req <= state_d == ST_REQ;
            if (fire) begin
                switch_reason <= fire_done ? REASON_DONE : fire_io ? REASON_IO : REASON_QUANTUM;
                saved_pid <= cur_pid;
                saved_pc <= fire_done ? '0 : pc + PC_W'(1);
            end
            // next_* freeze while a request is pending, snapshotting the table as it enters REQ.
            if (state == ST_RUN || switch_ack) begin
                next_valid <= pick_valid;
                next_pid <= pick_pid;
                next_pc <= pick_valid ? pc_tab_d[pick_pid] : '0;
            end
        end
    end

`ifdef QSCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            preempt_count <= '0;
            io_count <= '0;
        end else begin
            if (fire_q && !(&preempt_count)) preempt_count <= preempt_count + 32'd1;
            if (fire_io) io_count <= io_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: table-driven vectors plus hand sequences, scoreboard of expected switch requests.
module tb_quantum_scheduler;
    localparam int PID_W = 3;
    localparam int PC_W = 32;

    logic clock = 1'b0, reset = 1'b1;
    logic instr_valid = 1'b0, io_instr = 1'b0, proc_done = 1'b0, create_valid = 1'b0, switch_ack = 1'b0;
    logic [PC_W-1:0] pc = '0, create_pc = '0;
    logic [PID_W-1:0] cur_pid = '0, create_pid = '0;
    logic switch_req, next_valid;
    logic [1:0] switch_reason;
    logic [PID_W-1:0] saved_pid, next_pid;
    logic [PC_W-1:0] saved_pc, next_pc;
    logic [7:0] active_mask;
`ifdef QSCHED_STATS_EN
    logic [31:0] preempt_count, io_count;
`endif

    quantum_scheduler dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .pc(pc), .io_instr(io_instr),
        .proc_done(proc_done), .cur_pid(cur_pid), .create_valid(create_valid), .create_pid(create_pid),
        .create_pc(create_pc), .switch_ack(switch_ack), .switch_req(switch_req),
        .switch_reason(switch_reason), .saved_pid(saved_pid), .saved_pc(saved_pc),
        .next_valid(next_valid), .next_pid(next_pid), .next_pc(next_pc), .active_mask(active_mask)
`ifdef QSCHED_STATS_EN
        , .preempt_count(preempt_count), .io_count(io_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] reason;
        logic [2:0] pid;
        logic [31:0] spc;
        logic nv;
        logic [2:0] npid;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic cv;
        logic [2:0] cpid;
        logic [31:0] cpc;
        logic iv;
        logic [31:0] p;
        logic io;
        logic ack;
        logic req;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int total = 0, bad = 0;
    logic prev_req = 1'b0;

    function automatic exp_t ex(logic [1:0] r, logic [2:0] sp, logic [31:0] spc, logic nv, logic [2:0] np, logic [31:0] npc);
        exp_t e;
        e.reason = r; e.pid = sp; e.spc = spc; e.nv = nv; e.npid = np; e.npc = npc;
        return e;
    endfunction

    function automatic vec_t v(logic cv, logic [2:0] cpid, logic [31:0] cpc, logic iv, logic [31:0] p,
                               logic io, logic ack, logic req, exp_t e);
        vec_t r;
        r.cv = cv; r.cpid = cpid; r.cpc = cpc; r.iv = iv; r.p = p; r.io = io; r.ack = ack; r.req = req; r.e = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        if (switch_req && !prev_req) begin
            if (sb.size() == 0) chk("sb_unexpected_req", 32'(switch_req), 32'(0));
            else begin
                e = sb.pop_front();
                chk("sb_reason", 32'(switch_reason), 32'(e.reason));
                chk("sb_saved_pid", 32'(saved_pid), 32'(e.pid));
                chk("sb_saved_pc", saved_pc, e.spc);
                chk("sb_next_valid", 32'(next_valid), 32'(e.nv));
                chk("sb_next_pid", 32'(next_pid), 32'(e.npid));
                chk("sb_next_pc", next_pc, e.npc);
            end
        end
        prev_req = switch_req;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; io_instr = 1'b0; proc_done = 1'b0; create_valid = 1'b0; switch_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic create(input logic [2:0] id, input logic [31:0] cpc);
        create_valid = 1'b1; create_pid = id; create_pc = cpc;
        step();
        create_valid = 1'b0;
    endtask

    task automatic ack();
        idle_inputs();
        switch_ack = 1'b1;
        step();
        chk("ack_req_drop", 32'(switch_req), 32'(0));
        switch_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z = ex(2'd0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
        do_reset();
        chk("rst_req", 32'(switch_req), 32'(0));
        chk("rst_reason", 32'(switch_reason), 32'(0));
        chk("rst_saved_pid", 32'(saved_pid), 32'(0));
        chk("rst_saved_pc", saved_pc, 32'd0);
        chk("rst_next_valid", 32'(next_valid), 32'(0));
        chk("rst_next_pid", 32'(next_pid), 32'(0));
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_mask", 32'(active_mask), 32'(0));

        // Quantum expiry, then OS code interleaved with user code.
        cur_pid = 3'd1;
        vt.push_back(v(1'b1, 3'd1, 32'd400, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, z));
        for (int k = 0; k < 4; k++) vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'(400 + k), 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd404, 1'b0, 1'b0, 1'b1, ex(2'd0, 3'd1, 32'd405, 1'b1, 3'd1, 32'd405)));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd410, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd200, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd411, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd299, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd412, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd300, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b0, 32'd500, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd413, 1'b0, 1'b0, 1'b0, z));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b1, 32'd414, 1'b0, 1'b0, 1'b1, ex(2'd0, 3'd1, 32'd415, 1'b1, 3'd1, 32'd415)));
        vt.push_back(v(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, z));
        foreach (vt[i]) begin
            create_valid = vt[i].cv; create_pid = vt[i].cpid; create_pc = vt[i].cpc;
            instr_valid = vt[i].iv; pc = vt[i].p; io_instr = vt[i].io; switch_ack = vt[i].ack;
            if (vt[i].req && !prev_req) sb.push_back(vt[i].e);
            step();
            chk($sformatf("vec%0d_req", i), 32'(switch_req), 32'(vt[i].req));
        end
        idle_inputs();

        // IO yield with wrap-around pick; request held without ack stays frozen.
        do_reset();
        create(3'd0, 32'd600);
        create(3'd2, 32'd700);
        create(3'd5, 32'd800);
        cur_pid = 3'd5; instr_valid = 1'b1; pc = 32'd350; io_instr = 1'b1;
        sb.push_back(ex(2'd1, 3'd5, 32'd351, 1'b1, 3'd0, 32'd600));
        step();
        chk("io_req", 32'(switch_req), 32'(1));
        io_instr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'(1000 + i);
            create_valid = (i == 0); create_pid = 3'd6; create_pc = 32'h6000;
            step();
            chk($sformatf("hold%0d", i), {switch_req, switch_reason, next_valid, next_pid, 24'(saved_pc)},
                {1'b1, 2'd1, 1'b1, 3'd0, 24'd351});
            chk($sformatf("hold%0d_npc", i), next_pc, 32'd600);
        end
        chk("hold_mask", 32'(active_mask), 32'h65);
        ack();
        chk("post_ack_next_pid", 32'(next_pid), 32'(6));
        chk("post_ack_next_pc", next_pc, 32'h6000);

        // proc_done beats io_instr; last slot gone leaves no runnable process.
        do_reset();
        create(3'd2, 32'd900);
        cur_pid = 3'd2; instr_valid = 1'b1; pc = 32'd901; io_instr = 1'b1; proc_done = 1'b1;
        sb.push_back(ex(2'd2, 3'd2, 32'd0, 1'b0, 3'd0, 32'd0));
        step();
        chk("done_req", 32'(switch_req), 32'(1));
        chk("done_mask", 32'(active_mask), 32'(0));
        ack();

        // Exit and re-create of the same slot in one cycle; later duplicate create ignored.
        create(3'd4, 32'd1000);
        cur_pid = 3'd4; instr_valid = 1'b1; pc = 32'd1100; proc_done = 1'b1;
        create_valid = 1'b1; create_pid = 3'd4; create_pc = 32'd1234;
        sb.push_back(ex(2'd2, 3'd4, 32'd0, 1'b1, 3'd4, 32'd1234));
        step();
        chk("recreate_mask", 32'(active_mask), 32'h10);
        idle_inputs();
        create_valid = 1'b1; create_pid = 3'd4; create_pc = 32'd5555; switch_ack = 1'b1;
        step();
        idle_inputs();
        step();
        chk("dup_create_next_pc", next_pc, 32'd1234);

        // Reset while a request is pending.
        instr_valid = 1'b1; pc = 32'd1300; io_instr = 1'b1;
        sb.push_back(ex(2'd1, 3'd4, 32'd1301, 1'b1, 3'd4, 32'd1301));
        step();
        chk("pre_rst_req", 32'(switch_req), 32'(1));
        do_reset();
        chk("midreq_rst", {switch_req, switch_reason, saved_pid, next_valid, next_pid, active_mask},
            {1'b0, 2'd0, 3'd0, 1'b0, 3'd0, 8'd0});
        chk("midreq_rst_pcs", saved_pc | next_pc, 32'd0);

`ifdef QSCHED_STATS_EN
        create(3'd1, 32'd400);
        cur_pid = 3'd1;
        for (int q = 0; q < 3; q++) begin
            for (int k = 0; k < 5; k++) begin
                instr_valid = 1'b1; pc = 32'(400 + k);
                if (k == 4) sb.push_back(ex(2'd0, 3'd1, 32'd405, 1'b1, 3'd1, 32'd405));
                step();
            end
            ack();
        end
        for (int q = 0; q < 2; q++) begin
            instr_valid = 1'b1; pc = 32'd500; io_instr = 1'b1;
            sb.push_back(ex(2'd1, 3'd1, 32'd501, 1'b1, 3'd1, 32'd501));
            step();
            ack();
        end
        chk("preempt_count", preempt_count, 32'd3);
        chk("io_count", io_count, 32'd2);
`endif

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
